// File: rtl/control_sequencer.sv
// Hardwired control sequencer for the load/store datapath: fetch in T0-T2,
// then an opcode-dependent execute phase, with a HALT trap and async clear.
module control_sequencer (
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        Stop,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Rin,
  output logic        GRA,
  output logic        GRB,
  output logic        GRC,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  opcode,
  output logic        Run,
  output logic [3:0]  step
);

  localparam logic [3:0] S_T0    = 4'h0;
  localparam logic [3:0] S_T1    = 4'h1;
  localparam logic [3:0] S_T2    = 4'h2;
  localparam logic [3:0] S_T3    = 4'h3;
  localparam logic [3:0] S_T4    = 4'h4;
  localparam logic [3:0] S_T5    = 4'h5;
  localparam logic [3:0] S_T6    = 4'h6;
  localparam logic [3:0] S_T7    = 4'h7;
  localparam logic [3:0] S_HALT  = 4'hE;
  localparam logic [3:0] S_RESET = 4'hF;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_HALT = 5'b11010;

  logic [4:0] op;
  logic       is_ld, is_ldi, is_st, is_alu, is_addi, is_jr, is_halt;
  logic       last_step;
  logic [3:0] next_step;
  logic       unused_ir;

  // Register fields are routed by the datapath itself; only the opcode matters here.
  assign unused_ir = ^IR[26:0];
  assign op        = IR[31:27];

  assign is_ld   = (op == OP_LD);
  assign is_ldi  = (op == OP_LDI);
  assign is_st   = (op == OP_ST);
  assign is_alu  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  assign is_addi = (op == OP_ADDI);
  assign is_jr   = (op == OP_JR);
  assign is_halt = (op == OP_HALT);

  // Anything not recognised (including nop) finishes in T3 alongside jr and halt.
  always_comb begin
    last_step = 1'b0;
    case (step)
      S_T3:    last_step = !(is_ld || is_ldi || is_st || is_alu || is_addi);
      S_T5:    last_step = is_ldi || is_alu || is_addi;
      S_T7:    last_step = 1'b1;
      default: last_step = 1'b0;
    endcase
  end

  always_comb begin
    next_step = S_T0;
    case (step)
      S_RESET: next_step = S_T0;
      S_HALT:  next_step = S_HALT;
      S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (last_step)
          next_step = (is_halt || Stop) ? S_HALT : S_T0;
        else
          next_step = step + 4'h1;
      end
      default: next_step = S_T0;
    endcase
  end

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) step <= S_RESET;
    else       step <= next_step;
  end

  assign Run = (step != S_RESET) && (step != S_HALT);

  always_comb begin
    PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; Rout = 1'b0; BAout = 1'b0; Cout = 1'b0;
    MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0; Rin = 1'b0;
    GRA = 1'b0; GRB = 1'b0; GRC = 1'b0; IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
    opcode = 5'b00000;
    case (step)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if (is_ld || is_ldi || is_st) begin
          GRB = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (is_alu || is_addi) begin
          GRB = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_jr) begin
          GRA = 1'b1; Rout = 1'b1; PCin = 1'b1;
        end
      end
      S_T4: begin
        // Address and immediate arithmetic both reuse the ALU add.
        if (is_ld || is_ldi || is_st || is_addi) begin
          Cout = 1'b1; Zin = 1'b1; opcode = OP_ADD;
        end else if (is_alu) begin
          GRC = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op;
        end
      end
      S_T5: begin
        if (is_ld || is_st) begin
          Zlowout = 1'b1; MARin = 1'b1;
        end else if (is_ldi || is_alu || is_addi) begin
          Zlowout = 1'b1; GRA = 1'b1; Rin = 1'b1;
        end
      end
      S_T6: begin
        if (is_ld) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (is_st) begin
          GRA = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        end
      end
      S_T7: begin
        if (is_ld) begin
          MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1;
        end else if (is_st) begin
          Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
